// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types and constants.
// Holds the reset PC, instruction width, NOP and fetch entry.
package fetch_queue_pkg;

  localparam int          INST_W      = 32;
  localparam logic [31:0] FQ_RESET_PC = 32'h0100_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with push, pop, flush and a head port.
// Ports: clock, reset, flush, push/push_data, pop, count,
//        head_valid/head_data (head_data is zero when empty).
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output logic [W-1:0]               head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign head_valid = (count != '0);
  assign push_ok    = push & (count != FULL);
  assign pop_ok     = pop & head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push_ok & ~pop_ok: count <= count + 1'b1;
        pop_ok & ~push_ok: count <= count - 1'b1;
        default:           count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues imem reads, queues results.
// Ports: clock, reset, imem_addr/en/rdata, redirect_valid/pc,
//        dec_valid/inst/pc/ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic [31:0]       imem_addr,
  output logic              imem_en,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              dec_valid,
  output logic [INST_W-1:0] dec_inst,
  output logic [31:0]       dec_pc,
  input  logic              dec_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [AW:0]   count;
  logic [AW+1:0] used;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Credits cover buffered plus in-flight words; a same-cycle
  // pop is deliberately not counted as a free slot.
  assign used    = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign imem_en = ~reset & ~redirect_valid
                 & (used < (AW+2)'(DEPTH));

  assign imem_addr = fetch_pc;

  assign push            = inflight & ~redirect_valid;
  assign pop             = dec_valid & dec_ready & ~redirect_valid;
  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = req_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .count      (count),
    .head_valid (dec_valid),
    .head_data  (head_entry)
  );

  assign dec_inst = head_entry.inst;
  assign dec_pc   = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue.
// Memory returns pc ^ A5A5A5A5; a timed queue models issue-to-decode.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0100_0000;
  localparam logic [31:0] K     = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  // One-cycle memory; junk when not read so stray pushes show up.
  always @(posedge clock)
    imem_rdata <= imem_en ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Expected word: its PC and the first cycle it may appear.
  typedef struct {
    logic [31:0] pc;
    int          rdy;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mpc;
  bit          model_ok = 0;
  int          cyc      = 0;
  bit          arm      = 0;
  int          first_en = -1;
  int          first_vl = -1;

  // Monitor: compare DUT against the model, then step the model
  // to what the coming clock edge should do.
  always @(negedge clock) begin
    bit vis;
    bit exp_en;
    cyc++;
    vis    = model_ok && sb.size() > 0 && sb[0].rdy <= cyc;
    exp_en = model_ok && !reset && !redirect_valid
             && sb.size() < DEPTH;
    chk("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
    if (model_ok) begin
      chk("imem_addr", imem_addr, mpc);
      chk("dec_valid", {31'd0, dec_valid}, {31'd0, vis});
      if (vis) begin
        chk("dec_pc", dec_pc, sb[0].pc);
        chk("dec_inst", dec_inst, sb[0].pc ^ K);
      end else begin
        chk("dec_pc_idle", dec_pc, 32'd0);
        chk("dec_inst_idle", dec_inst, 32'd0);
      end
      chk("count_bound",
          {31'd0, dut.u_fifo.count <= DEPTH}, 32'd1);
    end
    if (arm && first_en < 0 && imem_en) first_en = cyc;
    if (arm && first_vl < 0 && dec_valid) first_vl = cyc;
    if (reset) begin
      sb.delete();
      mpc      = RPC;
      model_ok = 1;
    end else if (redirect_valid) begin
      sb.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else if (model_ok) begin
      if (vis && dec_ready) void'(sb.pop_front());
      if (exp_en) begin
        sb.push_back('{pc: mpc, rdy: cyc + 2});
        mpc = mpc + 32'd4;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int gap;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    dec_ready      = 1'b0;
    tick(3);

    // Release and stream with decode always ready.
    reset     = 1'b0;
    dec_ready = 1'b1;
    arm       = 1;
    tick(20);
    chk("first_latency", 32'(first_vl - first_en), 32'd2);

    // Decode stall, then drain.
    dec_ready = 1'b0;
    tick(10);
    dec_ready = 1'b1;
    tick(10);

    // Build 3 queued + 1 in flight, then redirect to unaligned target.
    redirect_valid = 1'b1;
    redirect_pc    = RPC;
    dec_ready      = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0103;
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    tick(2);
    @(negedge clock);
    chk("redir_valid_t3", {31'd0, dec_valid}, 32'd1);
    chk("redir_pc_t3", dec_pc, 32'h0100_0100);
    tick(6);

    // Back-to-back redirects: last wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0200;
    tick();
    redirect_pc    = 32'h0100_0300;
    tick();
    redirect_valid = 1'b0;
    tick(2);
    @(negedge clock);
    chk("b2b_valid", {31'd0, dec_valid}, 32'd1);
    chk("b2b_pc", dec_pc, 32'h0100_0300);
    tick(5);

    // Random ready and redirects.
    gap = $urandom_range(5, 20);
    for (int i = 0; i < 1000; i++) begin
      dec_ready = 1'($urandom_range(0, 1));
      if (gap == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = RPC + $urandom_range(0, 4095);
        gap            = $urandom_range(5, 20);
      end else begin
        redirect_valid = 1'b0;
        gap--;
      end
      tick();
    end
    redirect_valid = 1'b0;

    // Fill the queue, then reset mid-stream.
    dec_ready = 1'b0;
    tick(8);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    dec_ready = 1'b1;
    @(negedge clock);
    chk("rst_mid_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_mid_addr", imem_addr, RPC);
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
